exp_result_rx: RTL and testbench
================================

// Module: exp_result_rx
// PURPOSE
//  Receive-side endpoint for the exp(x) Taylor pipeline's output stream.
//  - Accepts Q7.25 results on a valid/ready handshake and buffers them in a first-word-fall-through FIFO.
//  - Drives the ready that stalls the pipeline, and re-presents results to a downstream consumer.
//  - Keeps a running count of received results and a sticky protocol-violation flag.
// PARAMETERS
//  WIDTH  32  result width (Q7.25)
//  DEPTH  8   FIFO entries; power of two, >=2
//  AFULL  6   o_almost_full asserts when occupancy >= AFULL (1..DEPTH)
// PORTS
//  clk            in   1                   clock, rising edge
//  reset          in   1                   asynchronous, active-low reset
//  i_valid        in   1                   result valid from pipeline
//  i_y            in   WIDTH               result data from pipeline
//  o_ready        out  1                   to pipeline ready/enable; low stalls pipeline
//  o_valid        out  1                   FIFO head valid to consumer
//  o_data         out  WIDTH               FIFO head data
//  i_ready        in   1                   consumer accepts head this cycle
//  o_count        out  $clog2(DEPTH)+1     current occupancy 0..DEPTH
//  o_almost_full  out  1                   occupancy >= AFULL
//  o_rx_total     out  32                  results accepted since reset, wraps at 2^32
//  o_overflow     out  1                   sticky: i_valid seen while o_ready low
// BEHAVIOUR
//  Reset (reset==0, async):
//  - Pointers, count, o_rx_total and o_overflow cleared.
//  - Resulting outputs: o_valid=0, o_ready=1, o_count=0, o_almost_full=0.
//  - o_data is don't-care while o_valid=0; memory array is not reset.
//  - Reset mid-operation discards all buffered entries immediately.
//  Write:
//  - wr = i_valid & o_ready. Stores i_y at wr_ptr; wr_ptr++ mod DEPTH; o_rx_total++.
//  Read:
//  - rd = o_valid & i_ready. rd_ptr++ mod DEPTH.
//  - o_data = mem[rd_ptr] (FWFT): head is visible before the consumer accepts it.
//  Outputs derived from registered state only:
//  - o_valid = (count != 0).
//  - o_ready = (count < DEPTH).
//  - No combinational path from i_ready to o_ready, or from i_valid to o_valid.
//  Count update per cycle: +1 on wr only, -1 on rd only, unchanged on wr&rd or neither.
//  Latency: write at edge N -> o_valid high after edge N (1 cycle, no empty bypass).
//  Full (count==DEPTH):
//  - o_ready=0, so no write that cycle even if a read occurs.
//  - Ready returns the cycle after the read.
//  Empty (count==0): o_valid=0; a simultaneous write is not readable until the next cycle.
//  Wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty is decided by count, not by pointers.
//  Protocol violation: i_valid=1 while o_ready=0 -> data dropped, o_rx_total unchanged, o_overflow=1 until reset.
//  Arithmetic: o_rx_total is unsigned and wraps 0xFFFFFFFF -> 0. Data passes through bit-exact.
// TESTING
//  1 Reset: assert reset=0 mid-stream with count=5 -> o_valid=0, o_count=0, o_ready=1, o_rx_total=0 while held low.
//  2 Pass-through: i_ready=1, push 0x02000000 then 0x0357F0B4 on back-to-back cycles
//    -> same values appear on o_data in order, each 1 cycle after acceptance; o_rx_total=2.
//  3 Fill: i_ready=0, push 8 words -> o_count=8, o_ready=0, o_almost_full=1 from count 6;
//    9th i_valid -> o_overflow=1, o_rx_total=8.
//  4 Full + simultaneous: at count=8 raise i_ready=1 with i_valid=1 -> no write that cycle, count=7;
//    next cycle the write is accepted and count stays 7.
//  5 Wrap: stream 20 words (0x100..0x113) with i_ready toggling every 3 cycles
//    -> output order exact, no loss, o_overflow=0, final o_count=0.
//  6 Counter wrap: force o_rx_total=0xFFFFFFFF, accept 1 word -> o_rx_total=0.

Source files
------------

// File: rtl/exp_result_rx.sv
// exp_result_rx: receive endpoint for the exp(x) pipeline result stream.
// Buffers Q7.25 results in a first-word-fall-through FIFO, drives the
// pipeline stall (o_ready), counts accepted results and flags drops.
module exp_result_rx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AFULL = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_y,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_almost_full,
  output logic [31:0]                o_rx_total,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   rx_total_q, rx_total_d;
  logic          overflow_q, overflow_d;
  logic          wr, rd;

  // Handshake flags and status outputs, all from registered state only
  always_comb begin
    o_valid       = (count_q != '0);
    o_ready       = (count_q < DEPTH_C);
    o_almost_full = (count_q >= AFULL_C);
    o_count       = count_q;
    o_rx_total    = rx_total_q;
    o_overflow    = overflow_q;
    o_data        = mem[rd_ptr_q];
    wr            = i_valid & o_ready;
    rd            = o_valid & i_ready;
  end

  // Next-state: pointers wrap naturally; full/empty tracked by count alone
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rx_total_d = rx_total_q;
    overflow_d = overflow_q | (i_valid & ~o_ready);
    if (wr) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      rx_total_d = rx_total_q + 32'd1;
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr, rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_total_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_total_q <= rx_total_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array is not reset; contents are only observable while count != 0
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr_q] <= i_y;
    end
  end

endmodule

// File: tb/tb_exp_result_rx.sv
// Directed testbench for exp_result_rx.
module tb_exp_result_rx;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_y;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic        i_ready;
  logic [3:0]  o_count;
  logic        o_almost_full;
  logic [31:0] o_rx_total;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;

  exp_result_rx #(.WIDTH(32), .DEPTH(8), .AFULL(6)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_y(i_y),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_count(o_count), .o_almost_full(o_almost_full),
    .o_rx_total(o_rx_total), .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_list [8];
    int mc, sent, recv, cyc;
    logic mwr, mrd;

    reset = 1'b0; i_valid = 1'b0; i_y = '0; i_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_afull", 32'(o_almost_full), 32'd0);
    chk("rst_total", o_rx_total, 32'd0);
    chk("rst_ovf",   32'(o_overflow), 32'd0);
    reset = 1'b1;
    tick();

    // Pass-through
    i_ready = 1'b1; i_valid = 1'b1; i_y = 32'h0200_0000;
    tick();
    chk("pt_valid0", 32'(o_valid), 32'd1);
    chk("pt_data0",  o_data, 32'h0200_0000);
    i_y = 32'h0357_F0B4;
    tick();
    chk("pt_count1", 32'(o_count), 32'd1);
    chk("pt_data1",  o_data, 32'h0357_F0B4);
    i_valid = 1'b0;
    tick();
    chk("pt_empty", 32'(o_valid), 32'd0);
    chk("pt_total", o_rx_total, 32'd2);

    // Reset mid-stream with five entries buffered
    i_ready = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_y = 32'h50 + 32'(k);
      tick();
    end
    i_valid = 1'b0;
    chk("mid_count5", 32'(o_count), 32'd5);
    reset = 1'b0;
    #1;
    chk("mid_valid", 32'(o_valid), 32'd0);
    chk("mid_count", 32'(o_count), 32'd0);
    chk("mid_ready", 32'(o_ready), 32'd1);
    chk("mid_total", o_rx_total, 32'd0);
    tick();
    chk("mid_hold_count", 32'(o_count), 32'd0);
    reset = 1'b1;
    tick();

    // Fill to full with consumer stalled
    i_ready = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_y = 32'hA0 + 32'(k);
      tick();
      chk("fill_count", 32'(o_count), 32'(k + 1));
      chk("fill_afull", 32'(o_almost_full), (k + 1 >= 6) ? 32'd1 : 32'd0);
    end
    chk("full_ready", 32'(o_ready), 32'd0);
    chk("full_ovf0",  32'(o_overflow), 32'd0);
    i_y = 32'hDEAD;
    tick();
    chk("ovf_flag",  32'(o_overflow), 32'd1);
    chk("ovf_total", o_rx_total, 32'd8);
    chk("ovf_count", 32'(o_count), 32'd8);
    chk("ovf_head",  o_data, 32'hA0);

    // Full with simultaneous read and write request
    i_ready = 1'b1; i_valid = 1'b1; i_y = 32'h55;
    tick();
    chk("fs_count7", 32'(o_count), 32'd7);
    chk("fs_total8", o_rx_total, 32'd8);
    chk("fs_head",   o_data, 32'hA1);
    chk("fs_ready",  32'(o_ready), 32'd1);
    tick();
    chk("fs_count_hold", 32'(o_count), 32'd7);
    chk("fs_total9", o_rx_total, 32'd9);
    i_valid = 1'b0;
    exp_list[0] = 32'hA2; exp_list[1] = 32'hA3; exp_list[2] = 32'hA4;
    exp_list[3] = 32'hA5; exp_list[4] = 32'hA6; exp_list[5] = 32'hA7;
    exp_list[6] = 32'h55; exp_list[7] = 32'h0;
    for (int k = 0; k < 7; k++) begin
      chk("fs_drain", o_data, exp_list[k]);
      tick();
    end
    chk("fs_empty", 32'(o_count), 32'd0);
    chk("fs_ovf_sticky", 32'(o_overflow), 32'd1);

    // Clear the sticky flag before streaming
    reset = 1'b0; i_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Wrap stream: 20 words, consumer ready toggles every 3 cycles
    mc = 0; sent = 0; recv = 0; cyc = 0;
    while (recv < 20 && cyc < 300) begin
      i_ready = ((cyc / 3) % 2) == 0;
      chk("wr_ready", 32'(o_ready), (mc < 8) ? 32'd1 : 32'd0);
      chk("wr_count", 32'(o_count), 32'(mc));
      i_valid = (sent < 20) && (mc < 8);
      i_y = 32'h100 + 32'(sent);
      mwr = i_valid;
      mrd = (mc != 0) && i_ready;
      if (mrd) begin
        chk("wr_data", o_data, 32'h100 + 32'(recv));
        recv++;
      end
      if (mwr) sent++;
      mc = mc + (mwr ? 1 : 0) - (mrd ? 1 : 0);
      tick();
      cyc++;
    end
    i_valid = 1'b0; i_ready = 1'b0;
    chk("wr_recv", 32'(recv), 32'd20);
    chk("wr_final_count", 32'(o_count), 32'd0);
    chk("wr_ovf", 32'(o_overflow), 32'd0);
    chk("wr_total", o_rx_total, 32'd20);

    // Counter wrap at 2^32
    force dut.rx_total_d = 32'hFFFF_FFFF;
    tick();
    release dut.rx_total_d;
    #1;
    chk("cw_preset", o_rx_total, 32'hFFFF_FFFF);
    i_valid = 1'b1; i_y = 32'h0357_F0B4;
    tick();
    i_valid = 1'b0;
    chk("cw_wrap", o_rx_total, 32'd0);
    chk("cw_data", o_data, 32'h0357_F0B4);
    chk("cw_count", 32'(o_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
